fetch_pc_unit: RTL
==================

Name: fetch_pc_unit

Overview:
- Instruction-fetch front end that sits directly upstream of the gshare predictor and consumes its PCNextF.
- Owns the PC register (PCF/PCPlus4F, which feed the predictor) and issues one instruction-memory request per PC over a req/gnt/rvalid handshake that tolerates variable latency.
- Presents InstrF/InstrValidF to the IF/ID register and discards stale responses after a redirect.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- MAX_WAIT, 16, cycles allowed in WAIT before imem_timeout is set.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- PCNextF  in  32  next PC from predictor; already the corrected PC when RedirectF=1.
- StallF  in  1  hazard-unit stall of IF.
- RedirectF  in  1  mispredict redirect (mispredictE); load PCNextF now.
- imem_req  out  1  request valid.
- imem_addr  out  32  request word address (= PCF).
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response valid; at most one outstanding.
- imem_rdata  in  32  response instruction.
- PCF  out  32  current fetch PC.
- PCPlus4F  out  32  PCF+4, mod 2^32.
- InstrF  out  32  instruction for PCF.
- InstrValidF  out  1  InstrF valid this cycle.
- FetchBusyF  out  1  = ~InstrValidF; to hazard unit.
- imem_timeout  out  1  sticky; WAIT exceeded MAX_WAIT.

Behaviour:
- Reset (async):
  - state=REQ, PCF=RESET_PC, PCPlus4F=RESET_PC+4.
  - Buffer=0, wait counter=0, imem_timeout=0.
  - Outputs: InstrF=0, InstrValidF=0, imem_req=1 from the first cycle after reset deasserts.
- PC load: PCF <= {PCNextF[31:2],2'b00}. PCPlus4F is combinational from PCF; it wraps 32'hFFFF_FFFC -> 0.
- FSM states:
  - REQ: imem_req=1, imem_addr=PCF.
    - gnt -> WAIT.
    - RedirectF & ~gnt -> load PC, stay REQ.
    - RedirectF & gnt -> load PC, KILL (granted request was for the old PC).
  - WAIT: imem_req=0; wait counter increments each cycle.
    - rvalid & ~RedirectF: InstrF=imem_rdata, InstrValidF=1, same cycle (bypass).
      - ~StallF -> load PC, REQ.
      - StallF -> buffer<=imem_rdata, HOLD.
    - rvalid & RedirectF -> drop data, InstrValidF=0, load PC, REQ.
    - ~rvalid & RedirectF -> load PC, KILL.
  - HOLD: InstrF=buffer, InstrValidF=1, imem_req=0.
    - RedirectF -> load PC, InstrValidF=0, REQ.
    - ~StallF -> load PC, REQ.
  - KILL: imem_req=0, InstrValidF=0; waits for the orphan response.
    - rvalid -> discard, REQ.
    - RedirectF -> load PC, stay KILL.
    - Redirect and rvalid together -> load PC, REQ.
- PC only changes on a PC load. StallF never blocks a redirect, and RedirectF has priority over StallF everywhere.
- InstrF=0 whenever InstrValidF=0.
- Wait counter: clears on entry to WAIT. When it reaches MAX_WAIT while still in WAIT, imem_timeout<=1 and stays 1 until reset. The FSM keeps waiting.
- imem_rvalid outside WAIT/KILL is a protocol violation; it is ignored.
- One outstanding request. Best-case throughput is one instruction per 2 cycles with 1-cycle latency (REQ, WAIT).

Test Plan:
- Reset with RESET_PC=32'h100, memory gnt immediate, 1-cycle rvalid, PCNextF=PCPlus4F, no stall -> imem_addr sequence 0x100, 0x104, 0x108. InstrValidF pulses every 2nd cycle with the matching rdata.
- rvalid with rdata=32'hDEAD_BEEF while StallF=1 for 3 cycles -> InstrF holds 32'hDEAD_BEEF with InstrValidF=1 for 4 cycles. PCF stays constant, then advances on the first unstalled cycle.
- RedirectF=1 with PCNextF=32'h200 in WAIT, rvalid arrives 2 cycles later -> state KILL, response discarded, InstrValidF=0. Next request has imem_addr=0x200.
- RedirectF together with gnt in REQ (PCF=0x104, PCNextF=0x300) -> KILL. The 0x104 response is dropped and the next request addr is 0x300. Also check redirect coincident with rvalid in KILL -> REQ at the new PC.
- PCNextF=32'h0000_0206 -> PCF=32'h204. With PCF=32'hFFFF_FFFC -> PCPlus4F=0.
- Hold rvalid low for MAX_WAIT=16 cycles -> imem_timeout rises and stays 1 after a later rvalid. Assert reset mid-WAIT -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory request/response bundle: req/gnt request phase,
// rvalid/rdata response phase, at most one request outstanding.
interface fetch_pc_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    // Fetch unit side: issues requests, consumes responses.
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    // Memory side: accepts requests, returns responses.
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch front end. Owns the fetch PC, issues one memory request
// per PC, delivers the instruction to IF/ID and discards responses that were
// made stale by a redirect.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MAX_WAIT = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            PCNextF,
    input  logic                   StallF,
    input  logic                   RedirectF,
    fetch_pc_unit_if.master        imem,
    output logic [31:0]            PCF,
    output logic [31:0]            PCPlus4F,
    output logic [31:0]            InstrF,
    output logic                   InstrValidF,
    output logic                   FetchBusyF,
    output logic                   imem_timeout
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_KILL
    } state_t;

    state_t           state_q,   state_d;
    logic [31:0]      pc_q,      pc_d;
    logic [31:0]      buf_q,     buf_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             timeout_q, timeout_d;

    // Word-aligned PC candidate; the low two bits of PCNextF are dropped.
    logic [31:0] pc_load;
    assign pc_load = PCNextF & ~32'h0000_0003;

    // Next-state, PC load, buffer, wait counter and outputs.
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        buf_d         = buf_q;
        wait_cnt_d    = wait_cnt_q;
        timeout_d     = timeout_q;
        imem.imem_req = 1'b0;
        InstrF        = 32'h0;
        InstrValidF   = 1'b0;

        unique case (state_q)
            S_REQ: begin
                imem.imem_req = 1'b1;
                if (RedirectF) begin
                    pc_d = pc_load;
                end
                if (imem.imem_gnt) begin
                    // A grant that coincides with a redirect fetched the old PC.
                    state_d    = RedirectF ? S_KILL : S_WAIT;
                    wait_cnt_d = '0;
                end
            end

            S_WAIT: begin
                if (wait_cnt_q != CNT_MAX) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end else begin
                    timeout_d = 1'b1;
                end
                if (imem.imem_rvalid && !RedirectF) begin
                    InstrF      = imem.imem_rdata;
                    InstrValidF = 1'b1;
                    if (StallF) begin
                        buf_d   = imem.imem_rdata;
                        state_d = S_HOLD;
                    end else begin
                        pc_d    = pc_load;
                        state_d = S_REQ;
                    end
                end else if (imem.imem_rvalid) begin
                    pc_d    = pc_load;
                    state_d = S_REQ;
                end else if (RedirectF) begin
                    // Response still in flight for the old PC; drain it first.
                    pc_d    = pc_load;
                    state_d = S_KILL;
                end
            end

            S_HOLD: begin
                if (RedirectF) begin
                    pc_d    = pc_load;
                    state_d = S_REQ;
                end else begin
                    InstrF      = buf_q;
                    InstrValidF = 1'b1;
                    if (!StallF) begin
                        pc_d    = pc_load;
                        state_d = S_REQ;
                    end
                end
            end

            S_KILL: begin
                if (RedirectF) begin
                    pc_d = pc_load;
                end
                if (imem.imem_rvalid) begin
                    state_d = S_REQ;
                end
            end

            default: state_d = S_REQ;
        endcase
    end

    // State, PC, buffer, wait counter and sticky timeout registers.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    // NOTE: the instruction buffer is reset too, so InstrF is never X after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            buf_q      <= 32'h0;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            buf_q      <= buf_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign imem.imem_addr = pc_q;
    assign PCF            = pc_q;
    assign PCPlus4F       = pc_q + 32'd4;
    assign FetchBusyF     = ~InstrValidF;
    assign imem_timeout   = timeout_q;

endmodule
